// File: rtl/sipo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sipo_pkg                                                         |
// | Purpose : Shared types and helpers for the serial-in/parallel-out          |
// |           deserializer: assembly FSM state encoding and the count-width    |
// |           function.                                                        |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package sipo_pkg;

  // Assembly FSM states: IDLE holds no partial bits, SHIFT holds 1..WIDTH-1.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  // Ceiling log2, evaluated at elaboration time for counter widths.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_bit_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sipo_bit_counter                                                 |
// | Purpose : Counts received bits of the word being assembled. Wraps from     |
// |           WIDTH-1 back to 0 when the final bit of a word arrives.          |
// | Ports   : clk, rst        - clock, synchronous active-high reset           |
// |           clr_i           - force count to 0 (highest priority)            |
// |           load_one_i      - force count to 1 (first bit of a new word)     |
// |           inc_i           - advance by one, wrapping at WIDTH-1            |
// |           count_o         - current count                                  |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          load_one_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_ONE  = CW'(1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_one_i) begin
      count_d = c_ONE;
    end else if (inc_i) begin
      count_d = (count_q == c_LAST) ? '0 : count_q + c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sipo_deserializer                                                |
// | Purpose : Collects serial bits into WIDTH-bit words and presents them on a |
// |           valid/ready interface. Flags dropped words (overrun) and allows  |
// |           frame resynchronisation.                                         |
// | Ports   : clk, rst        - clock, synchronous active-high reset           |
// |           serial_in       - data bit, used when bit_valid=1                |
// |           bit_valid       - serial_in carries a bit this cycle             |
// |           frame_start     - discard any partial word                       |
// |           parallel_out    - assembled word, stable while out_valid=1       |
// |           out_valid       - parallel_out holds an unconsumed word          |
// |           out_ready       - consumer accepts the word                      |
// |           busy            - a partial word is being assembled              |
// |           overrun         - sticky flag: a completed word was dropped      |
// |           overrun_clr     - clears overrun                                 |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int            CW     = clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [CW-1:0]    w_count;
  logic [WIDTH-1:0] w_shifted;
  logic             w_last;
  logic             w_complete;
  logic             w_accept;
  logic             w_drop;

  // Shift direction decides where the first received bit ends up.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shifted = {sreg_q[WIDTH-2:0], serial_in};
    end else begin : g_lsb_first
      assign w_shifted = {serial_in, sreg_q[WIDTH-1:1]};
    end
  endgenerate

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (frame_start & ~bit_valid),
    .load_one_i (bit_valid & (frame_start | (state_q == S_IDLE))),
    .inc_i      (bit_valid & ~frame_start & (state_q == S_SHIFT)),
    .count_o    (w_count)
  );

  assign w_last     = (w_count == c_LAST);
  // frame_start overrides completion: the bit it carries starts a new word.
  assign w_complete = bit_valid & ~frame_start & (state_q == S_SHIFT) & w_last;
  // The output slot is free if empty or being emptied on this very edge.
  assign w_accept   = w_complete & (~valid_q | out_ready);
  assign w_drop     = w_complete & valid_q & ~out_ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    pout_d  = pout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (frame_start) begin
      state_d = bit_valid ? S_SHIFT : S_IDLE;
    end else if (bit_valid) begin
      if (state_q == S_IDLE) begin
        state_d = S_SHIFT;
      end else begin
        state_d = w_last ? S_IDLE : S_SHIFT;
      end
    end

    // Stale bits left behind by a resync are pushed out before a word completes.
    if (bit_valid) begin
      sreg_d = w_shifted;
    end

    if (w_accept) begin
      pout_d  = w_shifted;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (w_drop) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      pout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      pout_q  <= pout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign parallel_out = pout_q;
  assign out_valid    = valid_q;
  assign busy         = (state_q == S_SHIFT);
  assign overrun      = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sipo_deserializer                                             |
// | Purpose : Self-checking bench for sipo_deserializer. Two instances (MSB    |
// |           first and LSB first) share stimulus; a bit-list reference model  |
// |           feeds per-instance scoreboards checked by a negedge monitor.     |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sipo_deserializer;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         serial_in;
  logic         bit_valid;
  logic         frame_start;
  logic         out_ready;
  logic         overrun_clr;
  logic [W-1:0] po0, po1;
  logic         ov0, ov1;
  logic         busy0, busy1;
  logic         ovr0, ovr1;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1)) u_dut_msb (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .frame_start  (frame_start),
    .parallel_out (po0),
    .out_valid    (ov0),
    .out_ready    (out_ready),
    .busy         (busy0),
    .overrun      (ovr0),
    .overrun_clr  (overrun_clr)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(0)) u_dut_lsb (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .frame_start  (frame_start),
    .parallel_out (po1),
    .out_valid    (ov1),
    .out_ready    (out_ready),
    .busy         (busy1),
    .overrun      (ovr1),
    .overrun_clr  (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // Reference model: list of received bits of the partial word, one output slot.
  logic         bits[$];
  logic         m_valid;
  logic         m_ovr;
  logic [W-1:0] m_w0, m_w1;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  // Model state as seen after the most recent clock edge.
  logic         e_valid, e_busy, e_ovr;
  logic [W-1:0] e_w0, e_w1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic bv,
                      input logic fs, input logic rd, input logic oc);
    logic         done;
    logic         drop;
    logic [W-1:0] c0, c1;
    rst = r; serial_in = s; bit_valid = bv; frame_start = fs;
    out_ready = rd; overrun_clr = oc;
    done = 1'b0; drop = 1'b0; c0 = '0; c1 = '0;
    if (r) begin
      bits.delete(); q0.delete(); q1.delete();
      m_valid = 1'b0; m_ovr = 1'b0; m_w0 = '0; m_w1 = '0;
    end else begin
      if (fs) begin
        bits.delete();
        if (bv) bits.push_back(s);
      end else if (bv) begin
        bits.push_back(s);
        if (bits.size() == W) begin
          done = 1'b1;
          for (int i = 0; i < W; i++) begin
            c0[W-1-i] = bits[i];
            c1[i]     = bits[i];
          end
          bits.delete();
        end
      end
      if (done) begin
        if (!m_valid || rd) begin
          m_valid = 1'b1; m_w0 = c0; m_w1 = c1;
          q0.push_back(c0); q1.push_back(c1);
        end else begin
          drop = 1'b1;
        end
      end else if (m_valid && rd) begin
        m_valid = 1'b0;
      end
      if (drop) m_ovr = 1'b1;
      else if (oc) m_ovr = 1'b0;
    end
    @(posedge clk);
    #1;
    e_valid = m_valid; e_ovr = m_ovr; e_busy = (bits.size() != 0);
    e_w0 = m_w0; e_w1 = m_w1;
    #1;
  endtask

  task automatic send(input logic [W-1:0] word, input logic rd);
    for (int i = W - 1; i >= 0; i--) step(1'b0, word[i], 1'b1, 1'b0, rd, 1'b0);
  endtask

  task automatic idle(input logic rd);
    step(1'b0, 1'b0, 1'b0, 1'b0, rd, 1'b0);
  endtask

  // Monitor: compares visible state every cycle and pops the scoreboard on transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid_msb", {7'd0, ov0}, {7'd0, e_valid});
      chk("valid_lsb", {7'd0, ov1}, {7'd0, e_valid});
      chk("busy_msb", {7'd0, busy0}, {7'd0, e_busy});
      chk("busy_lsb", {7'd0, busy1}, {7'd0, e_busy});
      chk("overrun_msb", {7'd0, ovr0}, {7'd0, e_ovr});
      chk("overrun_lsb", {7'd0, ovr1}, {7'd0, e_ovr});
      chk("pout_msb", {4'd0, po0}, {4'd0, e_w0});
      chk("pout_lsb", {4'd0, po1}, {4'd0, e_w1});
      if (!rst && out_ready && ov0) begin
        if (q0.size() == 0) chk("sb_msb_empty", 8'd1, 8'd0);
        else chk("sb_msb", {4'd0, po0}, {4'd0, q0.pop_front()});
      end
      if (!rst && out_ready && ov1) begin
        if (q1.size() == 0) chk("sb_lsb_empty", 8'd1, 8'd0);
        else chk("sb_lsb", {4'd0, po1}, {4'd0, q1.pop_front()});
      end
    end
  end

  initial begin
    bits.delete();
    m_valid = 1'b0; m_ovr = 1'b0; m_w0 = '0; m_w1 = '0;
    e_valid = 1'b0; e_ovr = 1'b0; e_busy = 1'b0; e_w0 = '0; e_w1 = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_pout", {4'd0, po0}, 8'd0);
    chk("reset_flags", {5'd0, ov0, busy0, ovr0}, 8'd0);
    idle(1'b1);

    // 1: back-to-back bits 1,0,1,1
    send(4'b1011, 1'b1);
    chk("t1_msb_word", {4'd0, po0}, 8'h0B);
    chk("t1_lsb_word", {4'd0, po1}, 8'h0D);
    chk("t1_valid", {7'd0, ov0}, 8'd1);
    idle(1'b1);
    chk("t1_valid_one_cycle", {7'd0, ov0}, 8'd0);

    // 2: bits 1,1,0,1 with three idle cycles between bits
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b0, ((4'b1101 >> i) & 4'b1) != 0, 1'b1, 1'b0, 1'b1, 1'b0);
      if (i != 0) begin
        repeat (3) idle(1'b1);
        chk("t2_no_early_out", {7'd0, ov0}, 8'd0);
      end
    end
    chk("t2_word", {4'd0, po0}, 8'h0D);
    idle(1'b1);

    // 3: consumer stalled, second word dropped
    send(4'hA, 1'b0);
    send(4'h5, 1'b0);
    idle(1'b0);
    chk("t3_held_word", {4'd0, po0}, 8'h0A);
    chk("t3_overrun", {7'd0, ovr0}, 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_overrun_clr", {7'd0, ovr0}, 8'd0);
    idle(1'b1);

    // 4: completion in the same cycle as a transfer
    send(4'h3, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_word", {4'd0, po0}, 8'h0C);
    chk("t4_flags", {6'd0, ov0, ovr0}, 8'b10);
    idle(1'b1);

    // 5: resync with a bit, then resync alone
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_word", {4'd0, po0}, 8'h06);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_busy_cleared", {7'd0, busy0}, 8'd0);

    // 6: reset mid-word
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_reset_outputs", {po0, ov0, busy0, ovr0, 1'b0}, 8'd0);
    send(4'b0111, 1'b1);
    chk("t6_word", {4'd0, po0}, 8'h07);
    idle(1'b1);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0));
    end
    repeat (3) idle(1'b1);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
